// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared machine-mode CSR definitions: addresses, write-op encoding, cause codes,
// mstatus bit positions and address-decode helpers.
package ysyx_22040632_riscv_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Matches funct3[1:0] of csrrw/csrrs/csrrc; 00 behaves as a plain write.
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_W    = 2'b01,
        CSR_OP_S    = 2'b10,
        CSR_OP_C    = 2'b11
    } csr_op_e;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [4:0] EXC_ILLEGAL_INSTR = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT    = 5'd3;
    localparam logic [4:0] EXC_ECALL_M       = 5'd11;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LO   = 11;
    localparam int unsigned MSTATUS_MPP_HI   = 12;

    function automatic logic csr_implemented(input logic [11:0] addr, input logic is_rv32);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: return 1'b1;
            CSR_MCYCLEH, CSR_MINSTRETH:                     return is_rv32;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic csr_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/ysyx_22040632_csr_counter.sv
// 64-bit free-running CSR counter; a write to either half takes precedence over the increment.
module ysyx_22040632_csr_counter (
    input  logic        clk,
    input  logic        rrst_n,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] count
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (we_lo || we_hi) begin
            if (we_lo) count_d[31:0]  = wdata_lo;
            if (we_hi) count_d[63:32] = wdata_hi;
        end else if (inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ysyx_22040632_mcsr_unit.sv
// Machine-mode CSR file with trap controller at the commit stage.
// Define YSYX_22040632_MTVEC_VECTORED_EN to make mtvec.MODE writable (vectored interrupts).
module ysyx_22040632_mcsr_unit
    import ysyx_22040632_riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned HART_ID = 0
) (
    input  logic            clk,
    input  logic            rrst_n,
    input  logic [11:0]     rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_illegal,
    input  logic            rd_wr_intent,
    input  logic            commit_valid,
    input  logic [PC_W-1:0] commit_pc,
    input  logic            csr_we,
    input  csr_op_e         csr_op,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            irq_pending
);

    localparam logic IS_RV32 = (XLEN == 32);
`ifdef YSYX_22040632_MTVEC_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(2);
`else
    localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(3);
`endif

    logic            mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic            msip_q, msip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d, mie_q, mie_d, mscratch_q, mscratch_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [63:0]     mcycle, minstret;

    logic [XLEN-1:0] mstatus_rd, mip_live, mip_rd, irq_vec;
    logic [3:0]      irq_code;
    logic            exc_take, irq_take, trap_take, mret_take, wr_en, wr_addr_ok, vec_mode;
    logic [XLEN-1:0] wr_old, wr_new, wr_store, wr_fwd;
    logic [63:0]     wr64;
    logic [PC_W-1:0] trap_base, trap_pc;

    assign mstatus_rd = XLEN'({2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
    // MSIP is the OR of the software-written bit and the external source.
    assign mip_live   = XLEN'({irq_meip, 3'b000, irq_mtip, 3'b000, irq_msip, 3'b000});
    assign mip_rd     = mip_live | XLEN'({msip_q, 3'b000});

    function automatic logic [XLEN-1:0] csr_read(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS:   return mstatus_rd;
            CSR_MTVEC:     return mtvec_q;
            CSR_MEPC:      return mepc_q;
            CSR_MCAUSE:    return mcause_q;
            CSR_MTVAL:     return mtval_q;
            CSR_MIE:       return mie_q;
            CSR_MIP:       return mip_rd;
            CSR_MSCRATCH:  return mscratch_q;
            CSR_MHARTID:   return XLEN'(HART_ID);
            CSR_MCYCLE:    return XLEN'(mcycle);
            CSR_MINSTRET:  return XLEN'(minstret);
            CSR_MCYCLEH:   return IS_RV32 ? XLEN'(mcycle[63:32]) : '0;
            CSR_MINSTRETH: return IS_RV32 ? XLEN'(minstret[63:32]) : '0;
            default:       return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] csr_wmask(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS: return XLEN'(12'h088);
            CSR_MIE:     return XLEN'(12'h888);
            CSR_MIP:     return XLEN'(12'h008);
            CSR_MEPC:    return ~XLEN'(3);
            CSR_MTVEC:   return MTVEC_WMASK;
            default:     return '1;
        endcase
    endfunction

    // Bits that read back regardless of what was written.
    function automatic logic [XLEN-1:0] csr_rd_fixed(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS: return XLEN'(13'h1800);
            CSR_MIP:     return mip_live;
            default:     return '0;
        endcase
    endfunction

    always_comb begin
        wr_old = csr_read(csr_waddr);
        case (csr_op)
            CSR_OP_S: wr_new = wr_old | csr_wdata;
            CSR_OP_C: wr_new = wr_old & ~csr_wdata;
            default:  wr_new = csr_wdata;
        endcase
        wr_store = wr_new & csr_wmask(csr_waddr);
        wr_fwd   = wr_store | csr_rd_fixed(csr_waddr);
    end

    assign irq_vec     = mie_q & mip_rd;
    assign irq_pending = mstatus_mie_q & (|irq_vec);

    always_comb begin
        if (irq_vec[11])     irq_code = IRQ_MEI;
        else if (irq_vec[3]) irq_code = IRQ_MSI;
        else                 irq_code = IRQ_MTI;
    end

    assign exc_take   = commit_valid & exc_valid;
    assign irq_take   = commit_valid & ~exc_valid & irq_pending;
    assign trap_take  = exc_take | irq_take;
    assign mret_take  = commit_valid & mret_valid & ~trap_take;
    assign wr_addr_ok = csr_implemented(csr_waddr, IS_RV32) & ~csr_read_only(csr_waddr);
    assign wr_en      = commit_valid & csr_we & ~trap_take & ~mret_valid & wr_addr_ok;

`ifdef YSYX_22040632_MTVEC_VECTORED_EN
    assign vec_mode = mtvec_q[0];
`else
    assign vec_mode = 1'b0;
`endif
    assign trap_base = PC_W'(mtvec_q & ~XLEN'(3));
    assign trap_pc   = (irq_take && vec_mode) ? trap_base + PC_W'({irq_code, 2'b00}) : trap_base;

    always_comb begin
        mstatus_mie_d    = mstatus_mie_q;
        mstatus_mpie_d   = mstatus_mpie_q;
        msip_d           = msip_q;
        mtvec_d          = mtvec_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mie_d            = mie_q;
        mscratch_d       = mscratch_q;
        if (trap_take) begin
            mepc_d         = XLEN'(commit_pc) & ~XLEN'(3);
            mcause_d       = exc_take ? exc_cause : {1'b1, (XLEN-1)'(irq_code)};
            mtval_d        = exc_take ? exc_tval : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_waddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_store[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_store[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:    mtvec_d    = wr_store;
                CSR_MEPC:     mepc_d     = wr_store;
                CSR_MCAUSE:   mcause_d   = wr_store;
                CSR_MTVAL:    mtval_d    = wr_store;
                CSR_MIE:      mie_d      = wr_store;
                CSR_MIP:      msip_d     = wr_store[3];
                CSR_MSCRATCH: mscratch_d = wr_store;
                default: ;
            endcase
        end
        redirect_valid_d = trap_take | mret_take;
        if (trap_take)      redirect_pc_d = trap_pc;
        else if (mret_take) redirect_pc_d = PC_W'(mepc_q);
        else                redirect_pc_d = redirect_pc_q;
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            msip_q           <= 1'b0;
            mtvec_q          <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            mie_q            <= '0;
            mscratch_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            mstatus_mie_q    <= mstatus_mie_d;
            mstatus_mpie_q   <= mstatus_mpie_d;
            msip_q           <= msip_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mie_q            <= mie_d;
            mscratch_q       <= mscratch_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    // On RV32 the high halves live at separate addresses; on RV64 one write covers both.
    assign wr64 = 64'(wr_store);

    ysyx_22040632_csr_counter u_mcycle (
        .clk      (clk),
        .rrst_n   (rrst_n),
        .inc      (1'b1),
        .we_lo    (wr_en && csr_waddr == CSR_MCYCLE),
        .we_hi    (wr_en && csr_waddr == (IS_RV32 ? CSR_MCYCLEH : CSR_MCYCLE)),
        .wdata_lo (wr64[31:0]),
        .wdata_hi (IS_RV32 ? wr64[31:0] : wr64[63:32]),
        .count    (mcycle)
    );

    ysyx_22040632_csr_counter u_minstret (
        .clk      (clk),
        .rrst_n   (rrst_n),
        .inc      (commit_valid && !trap_take),
        .we_lo    (wr_en && csr_waddr == CSR_MINSTRET),
        .we_hi    (wr_en && csr_waddr == (IS_RV32 ? CSR_MINSTRETH : CSR_MINSTRET)),
        .wdata_lo (wr64[31:0]),
        .wdata_hi (IS_RV32 ? wr64[31:0] : wr64[63:32]),
        .count    (minstret)
    );

    always_comb begin
        if (wr_en && csr_waddr == rd_addr) rd_data = wr_fwd;
        else                               rd_data = csr_read(rd_addr);
    end

    assign rd_illegal = ~csr_implemented(rd_addr, IS_RV32) |
                        (rd_wr_intent & csr_read_only(rd_addr));

endmodule
